// File: rtl/usb_pkg.sv
// Shared USB definitions for the CRC16 transmit generator and the receive-side checker.
// Contents:
//   state_t             - packet phase of the TX CRC generator
//   USB_CRC16_INIT      - CRC register seed at packet start
//   USB_CRC16_POLY_REFL - bit-reflected x^16+x^15+x^2+1
//   USB_CRC16_RESIDUE   - register value left after running a good packet (payload + CRC) through the CRC
//   USB_COUNT_MAX       - saturation value of the 7-bit payload byte counter
package usb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      CRC_LO = 2'd2,
      CRC_HI = 2'd3
   } state_t;

   localparam logic [15:0] USB_CRC16_INIT      = 16'hFFFF;
   localparam logic [15:0] USB_CRC16_POLY_REFL = 16'hA001;
   localparam logic [15:0] USB_CRC16_RESIDUE   = 16'hB001;
   localparam logic [6:0]  USB_COUNT_MAX       = 7'd127;

endpackage

// File: rtl/usb_tx_dcrc_gen_crc16_byte_update.sv
// crc16_byte_update: combinational CRC16 update of one byte, LSB first.
// Ports:
//   crc     [15:0] in  - current CRC register
//   data    [7:0]  in  - byte to fold in
//   crc_upd [15:0] out - CRC after all eight bits
// Parameter POLY is the bit-reflected polynomial.
module crc16_byte_update
   import usb_pkg::*;
#(
   parameter logic [15:0] POLY = USB_CRC16_POLY_REFL
) (
   input  logic [15:0] crc,
   input  logic [7:0]  data,
   output logic [15:0] crc_upd
);

   // stage[i] is the register after i bits have been shifted in
   logic [15:0] stage [0:8];

   assign stage[0] = crc;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_bit
         assign stage[gi+1] = (stage[gi] >> 1) ^ ((stage[gi][0] ^ data[gi]) ? POLY : 16'h0000);
      end
   endgenerate

   assign crc_upd = stage[8];

endmodule

// File: rtl/usb_tx_dcrc_gen.sv
// usb_tx_dcrc_gen: passes the outgoing USB data-packet payload through one
// register stage while accumulating CRC16, then appends ~crc low byte and
// ~crc high byte. A zlp pulse in IDLE emits just the two CRC bytes.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   in_data/valid/last   - payload stream from the data source
//   in_ready             - byte accepted this cycle when in_valid is also 1
//   zlp                  - zero-length packet request (IDLE only)
//   out_data/valid/last  - byte stream to the serializer, out_last on CRC high byte
//   out_ready            - serializer consumes out_data
//   byte_count           - payload bytes accepted in the current packet (saturates at 127)
//   len_err              - sticky: more than MAX_LEN payload bytes accepted
module usb_tx_dcrc_gen
   import usb_pkg::*;
#(
   parameter int          MAX_LEN   = 64,
   parameter logic [15:0] CRC_INIT  = USB_CRC16_INIT,
   parameter logic [15:0] POLY_REFL = USB_CRC16_POLY_REFL
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   input  logic       zlp,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       out_last,
   input  logic       out_ready,
   output logic [6:0] byte_count,
   output logic       len_err
);

   localparam logic [6:0] MAX_LEN_CNT = 7'(MAX_LEN);

   state_t      state_reg, state_next;
   logic [15:0] crc_reg, crc_next;
   logic [7:0]  data_reg, data_next;
   logic        valid_reg, valid_next;
   logic        last_reg, last_next;
   logic [6:0]  count_reg, count_next;
   logic        len_err_reg, len_err_next;

   logic        slot_free;
   logic        accept;
   logic [15:0] crc_base;
   logic [15:0] crc_upd;

   // The output register can take a new byte when empty or being drained now.
   assign slot_free = !valid_reg || out_ready;
   assign in_ready  = ((state_reg == IDLE) || (state_reg == DATA)) && slot_free;
   assign accept    = in_valid && in_ready;

   // The first byte of a packet is folded into the seed, not into whatever
   // the previous packet left behind.
   assign crc_base = (state_reg == IDLE) ? CRC_INIT : crc_reg;

   crc16_byte_update #(
      .POLY (POLY_REFL)
   ) u_crc (
      .crc     (crc_base),
      .data    (in_data),
      .crc_upd (crc_upd)
   );

   always_comb begin
      state_next   = state_reg;
      crc_next     = crc_reg;
      data_next    = data_reg;
      valid_next   = valid_reg;
      last_next    = last_reg;
      count_next   = count_reg;
      len_err_next = len_err_reg;

      // Slot drained with nothing new loaded below: output goes empty.
      if (slot_free) begin
         valid_next = 1'b0;
         last_next  = 1'b0;
      end

      case (state_reg)
         IDLE: begin
            if (accept) begin
               data_next    = in_data;
               valid_next   = 1'b1;
               last_next    = 1'b0;
               crc_next     = crc_upd;
               count_next   = 7'd1;
               len_err_next = 1'b0;
               state_next   = in_last ? CRC_LO : DATA;
            end else if (zlp) begin
               crc_next     = CRC_INIT;
               count_next   = 7'd0;
               len_err_next = 1'b0;
               state_next   = CRC_LO;
            end
         end
         DATA: begin
            if (accept) begin
               data_next  = in_data;
               valid_next = 1'b1;
               last_next  = 1'b0;
               crc_next   = crc_upd;
               count_next = (count_reg == USB_COUNT_MAX) ? count_reg : count_reg + 7'd1;
               if (count_reg == MAX_LEN_CNT) begin
                  len_err_next = 1'b1;
               end
               if (in_last) begin
                  state_next = CRC_LO;
               end
            end
         end
         CRC_LO: begin
            if (slot_free) begin
               data_next  = ~crc_reg[7:0];
               valid_next = 1'b1;
               last_next  = 1'b0;
               state_next = CRC_HI;
            end
         end
         CRC_HI: begin
            if (slot_free) begin
               data_next  = ~crc_reg[15:8];
               valid_next = 1'b1;
               last_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         crc_reg     <= CRC_INIT;
         data_reg    <= 8'h00;
         valid_reg   <= 1'b0;
         last_reg    <= 1'b0;
         count_reg   <= 7'd0;
         len_err_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         crc_reg     <= crc_next;
         data_reg    <= data_next;
         valid_reg   <= valid_next;
         last_reg    <= last_next;
         count_reg   <= count_next;
         len_err_reg <= len_err_next;
      end
   end

   assign out_data   = data_reg;
   assign out_valid  = valid_reg;
   assign out_last   = last_reg;
   assign byte_count = count_reg;
   assign len_err    = len_err_reg;

endmodule

// File: tb/tb_usb_tx_dcrc_gen.sv
// Testbench for usb_tx_dcrc_gen: table of single-packet vectors plus
// hand-written sequences for back-to-back packets, length overflow and
// mid-packet reset. Outputs are collected by a negedge monitor.
module tb_usb_tx_dcrc_gen;

   logic       clk;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   logic       zlp;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_last;
   logic       out_ready;
   logic [6:0] byte_count;
   logic       len_err;

   usb_tx_dcrc_gen #(
      .MAX_LEN (64)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .zlp        (zlp),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_last   (out_last),
      .out_ready  (out_ready),
      .byte_count (byte_count),
      .len_err    (len_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit rdy_mode = 1'b0;
   int phase = 0;

   logic [7:0] cap_data [$];
   bit         cap_last [$];
   int         cap_cyc  [$];
   logic [7:0] exp_q    [$];
   bit         exp_last_q [$];

   typedef struct {
      string      name;
      int         len;
      logic [7:0] data [0:8];
      bit         use_zlp;
      bit         zlp_with_first;
      bit         stall;
      bit         hand;
      logic [7:0] exp_lo;
      logic [7:0] exp_hi;
   } vec_t;

   vec_t vecs [0:3];
   logic [7:0] ascii [0:8];

   function automatic logic [15:0] upd(input logic [15:0] c_in, input logic [7:0] b);
      logic [15:0] c;
      c = c_in;
      for (int i = 0; i < 8; i++) begin
         c = (c >> 1) ^ ((c[0] ^ b[i]) ? 16'hA001 : 16'h0000);
      end
      return c;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      tests++;
      fails++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // out_ready driver: held high, or pattern 1,0,0 repeating when stalling
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode) begin
            out_ready = (phase % 3 == 0);
            phase++;
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   // Output monitor: captures consumed bytes and checks hold-while-stalled
   initial begin
      bit         ps;
      logic [7:0] pd;
      bit         pl;
      ps = 1'b0;
      pd = 8'h00;
      pl = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            ps = 1'b0;
         end else begin
            if (ps) begin
               check("stall_hold", {22'd0, out_valid, out_last, out_data}, {22'd0, 1'b1, pl, pd});
            end
            if (out_valid && out_ready) begin
               cap_data.push_back(out_data);
               cap_last.push_back(out_last);
               cap_cyc.push_back(cyc);
            end
            ps = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running, expected done");
      $fatal(1, "watchdog");
   end

   task automatic clear_queues();
      cap_data.delete();
      cap_last.delete();
      cap_cyc.delete();
      exp_q.delete();
      exp_last_q.delete();
   endtask

   // Present one byte from posedge+1 and hold it until accepted; returns at posedge+1.
   task automatic send_byte(input logic [7:0] d, input logic l);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      if (!ok) bound_fail("accept");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      zlp      = 1'b0;
   endtask

   // From the end of the payload until the CRC high byte is loaded, in_ready must stay low.
   task automatic crc_phase_check(input string name);
      bit bad;
      bit done;
      bad  = 1'b0;
      done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if (out_valid && out_last) done = 1'b1;
         else if (in_ready) bad = 1'b1;
      end
      if (!done) bound_fail({name, "_crc_phase"});
      check({name, "_in_ready_crc"}, {31'd0, bad}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_caps(input int n, input string name);
      for (int k = 0; k < 1000 && cap_data.size() < n; k++) begin
         @(posedge clk);
         #1;
      end
      if (cap_data.size() < n) bound_fail({name, "_drain"});
   endtask

   task automatic compare_stream(input string name);
      check($sformatf("%s_count", name), cap_data.size(), exp_q.size());
      for (int k = 0; k < exp_q.size(); k++) begin
         if (k < cap_data.size()) begin
            check($sformatf("%s_byte%0d", name, k), {24'd0, cap_data[k]}, {24'd0, exp_q[k]});
            check($sformatf("%s_last%0d", name, k), {31'd0, cap_last[k]}, {31'd0, exp_last_q[k]});
         end
      end
   endtask

   task automatic residue_check(input int start, input int n, input string name);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int k = start; k < start + n && k < cap_data.size(); k++) begin
         c = upd(c, cap_data[k]);
      end
      check({name, "_residue"}, {16'd0, c}, 32'h0000B001);
   endtask

   // Queue a payload plus its CRC (from the model) as expected output.
   task automatic push_model_pkt(input int len, input logic [7:0] base);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 0; i < len; i++) begin
         exp_q.push_back(base + 8'(i));
         exp_last_q.push_back(1'b0);
         c = upd(c, base + 8'(i));
      end
      exp_q.push_back(~c[7:0]);
      exp_last_q.push_back(1'b0);
      exp_q.push_back(~c[15:8]);
      exp_last_q.push_back(1'b1);
   endtask

   task automatic push_ascii_pkt();
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back(ascii[i]);
         exp_last_q.push_back(1'b0);
      end
      exp_q.push_back(8'hC8);
      exp_last_q.push_back(1'b0);
      exp_q.push_back(8'hB4);
      exp_last_q.push_back(1'b1);
   endtask

   initial begin
      for (int i = 0; i < 9; i++) ascii[i] = 8'h31 + 8'(i);

      vecs[0].name = "ascii";     vecs[0].len = 9; vecs[0].use_zlp = 0; vecs[0].zlp_with_first = 0;
      vecs[0].stall = 0; vecs[0].hand = 1; vecs[0].exp_lo = 8'hC8; vecs[0].exp_hi = 8'hB4;
      vecs[1].name = "ascii_stall"; vecs[1].len = 9; vecs[1].use_zlp = 0; vecs[1].zlp_with_first = 0;
      vecs[1].stall = 1; vecs[1].hand = 1; vecs[1].exp_lo = 8'hC8; vecs[1].exp_hi = 8'hB4;
      vecs[2].name = "zlp";       vecs[2].len = 0; vecs[2].use_zlp = 1; vecs[2].zlp_with_first = 0;
      vecs[2].stall = 0; vecs[2].hand = 1; vecs[2].exp_lo = 8'h00; vecs[2].exp_hi = 8'h00;
      vecs[3].name = "byte00_zlp"; vecs[3].len = 1; vecs[3].use_zlp = 0; vecs[3].zlp_with_first = 1;
      vecs[3].stall = 0; vecs[3].hand = 1; vecs[3].exp_lo = 8'h40; vecs[3].exp_hi = 8'hBF;
      for (int v = 0; v < 4; v++) begin
         for (int i = 0; i < 9; i++) begin
            vecs[v].data[i] = (v < 2) ? ascii[i] : 8'h00;
         end
      end

      rst      = 1'b1;
      in_data  = 8'h00;
      in_valid = 1'b0;
      in_last  = 1'b0;
      zlp      = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      check("rst_out_last", {31'd0, out_last}, 32'd0);
      check("rst_byte_count", {25'd0, byte_count}, 32'd0);
      check("rst_len_err", {31'd0, len_err}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // table-driven single packets
      for (int v = 0; v < 4; v++) begin
         rdy_mode = vecs[v].stall;
         phase    = 0;
         @(posedge clk);
         #1;
         clear_queues();
         for (int i = 0; i < vecs[v].len; i++) begin
            exp_q.push_back(vecs[v].data[i]);
            exp_last_q.push_back(1'b0);
         end
         exp_q.push_back(vecs[v].exp_lo);
         exp_last_q.push_back(1'b0);
         exp_q.push_back(vecs[v].exp_hi);
         exp_last_q.push_back(1'b1);

         if (vecs[v].use_zlp) begin
            zlp = 1'b1;
            @(posedge clk);
            #1;
            zlp = 1'b0;
         end else begin
            for (int i = 0; i < vecs[v].len; i++) begin
               if (i == 0 && vecs[v].zlp_with_first) zlp = 1'b1;
               send_byte(vecs[v].data[i], (i == vecs[v].len - 1));
            end
         end
         crc_phase_check(vecs[v].name);
         wait_caps(vecs[v].len + 2, vecs[v].name);
         compare_stream(vecs[v].name);
         if (!vecs[v].stall && !vecs[v].use_zlp && cap_cyc.size() >= vecs[v].len + 2) begin
            check({vecs[v].name, "_consecutive"}, cap_cyc[vecs[v].len + 1] - cap_cyc[0], vecs[v].len + 1);
         end
         check({vecs[v].name, "_byte_count"}, {25'd0, byte_count}, vecs[v].len);
         residue_check(0, vecs[v].len + 2, vecs[v].name);
         $display("[TB] packet %s: %0d payload bytes, %0d bytes out", vecs[v].name, vecs[v].len, cap_data.size());
      end

      // back-to-back packets with no idle gap
      rdy_mode = 1'b0;
      @(posedge clk);
      #1;
      clear_queues();
      push_model_pkt(4, 8'h00);
      push_ascii_pkt();
      for (int i = 0; i < 4; i++) send_byte(8'(i), (i == 3));
      for (int i = 0; i < 9; i++) send_byte(ascii[i], (i == 8));
      crc_phase_check("b2b");
      wait_caps(17, "b2b");
      compare_stream("b2b");
      if (cap_cyc.size() >= 7) check("b2b_no_gap", cap_cyc[6] - cap_cyc[5], 1);
      residue_check(0, 6, "b2b_pkt1");
      residue_check(6, 11, "b2b_pkt2");
      $display("[TB] packet b2b: 4 + 9 payload bytes, %0d bytes out", cap_data.size());

      // length overflow: 65 bytes of 0xAA
      @(posedge clk);
      #1;
      clear_queues();
      for (int i = 1; i <= 65; i++) begin
         send_byte(8'hAA, (i == 65));
         if (i == 64) begin
            check("len64_len_err", {31'd0, len_err}, 32'd0);
            check("len64_count", {25'd0, byte_count}, 32'd64);
         end
         if (i == 65) begin
            check("len65_len_err", {31'd0, len_err}, 32'd1);
            check("len65_count", {25'd0, byte_count}, 32'd65);
         end
      end
      wait_caps(67, "len65");
      repeat (3) @(posedge clk);
      #1;
      check("len_err_sticky", {31'd0, len_err}, 32'd1);
      residue_check(0, 67, "len65");
      send_byte(8'h55, 1'b1);
      check("len_err_cleared", {31'd0, len_err}, 32'd0);
      check("next_pkt_count", {25'd0, byte_count}, 32'd1);
      wait_caps(70, "len_next");
      $display("[TB] packet len65: 65 payload bytes, len_err sticky then cleared");

      // reset in the middle of a packet
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) send_byte(8'h41 + 8'(i), 1'b0);
      rst = 1'b1;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      check("midrst_byte_count", {25'd0, byte_count}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_queues();
      repeat (3) @(posedge clk);
      #1;
      check("midrst_nothing_out", cap_data.size(), 0);
      push_ascii_pkt();
      for (int i = 0; i < 9; i++) send_byte(ascii[i], (i == 8));
      crc_phase_check("after_rst");
      wait_caps(11, "after_rst");
      compare_stream("after_rst");
      $display("[TB] packet after_rst: 9 payload bytes, %0d bytes out", cap_data.size());

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
